// File: rtl/data_demux_module_if.sv
// Bus bundle between the symbol source and the demultiplexer.
// The master side drives the multiplexed stream and its settings.
// The slave side (the demux) drives the per-channel outputs and status.
interface data_demux_module_if #(
    parameter int unsigned DW = 8
);
    logic          symbol_clk;
    logic [2:0]    switch_clk_cycles;
    logic [1:0]    mode;
    logic          frame_sync;
    logic [DW-1:0] mux_data;
    logic [DW-1:0] ds1_out;
    logic [DW-1:0] ds2_out;
    logic [DW-1:0] ds3_out;
    logic          ds1_valid;
    logic          ds2_valid;
    logic          ds3_valid;
    logic [1:0]    active_ch;
    logic          sync_err;

    modport master (
        output symbol_clk, switch_clk_cycles, mode, frame_sync, mux_data,
        input  ds1_out, ds2_out, ds3_out, ds1_valid, ds2_valid, ds3_valid,
               active_ch, sync_err
    );

    modport slave (
        input  symbol_clk, switch_clk_cycles, mode, frame_sync, mux_data,
        output ds1_out, ds2_out, ds3_out, ds1_valid, ds2_valid, ds3_valid,
               active_ch, sync_err
    );
endinterface

// File: rtl/data_demux_module.sv
// Splits the time-multiplexed symbol stream of data_mux_module back into
// DS1/DS2/DS3. symbol_clk is edge-detected in the clk domain; each rising
// edge (tick) writes mux_data to the current channel and pulses its valid.
module data_demux_module #(
    parameter int unsigned DW     = 8,
    parameter int unsigned CH_MAX = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    data_demux_module_if.slave    bus
);
    localparam int unsigned CW = $clog2(CH_MAX + 1);

    typedef enum logic [0:0] {IDLE, RUN} state_t;

    state_t        state, state_n;
    logic          sym_q;
    logic          tick;
    logic [1:0]    mode_q;
    logic [2:0]    sym_cnt, sym_cnt_n;
    logic [CW-1:0] ch_idx, ch_idx_n;
    logic [CW-1:0] cur_ch;
    logic [2:0]    cur_cnt;
    logic [2:0]    n_eff;
    logic [DW-1:0] d1_n, d2_n, d3_n;
    logic          v1_n, v2_n, v3_n;
    logic [1:0]    act_n;
    logic          err_n;

    // symbol_clk history register; runs through reset so release never sees a false edge
    always_ff @(posedge clk) begin
        sym_q <= bus.symbol_clk;
    end

    assign tick = bus.symbol_clk & ~sym_q & rst_n;

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            mode_q        <= bus.mode;
            sym_cnt       <= '0;
            ch_idx        <= CW'(1);
            bus.ds1_out   <= '0;
            bus.ds2_out   <= '0;
            bus.ds3_out   <= '0;
            bus.ds1_valid <= 1'b0;
            bus.ds2_valid <= 1'b0;
            bus.ds3_valid <= 1'b0;
            bus.active_ch <= '0;
            bus.sync_err  <= 1'b0;
        end else begin
            state         <= state_n;
            mode_q        <= bus.mode;
            sym_cnt       <= sym_cnt_n;
            ch_idx        <= ch_idx_n;
            bus.ds1_out   <= d1_n;
            bus.ds2_out   <= d2_n;
            bus.ds3_out   <= d3_n;
            bus.ds1_valid <= v1_n;
            bus.ds2_valid <= v2_n;
            bus.ds3_valid <= v3_n;
            bus.active_ch <= act_n;
            bus.sync_err  <= err_n;
        end
    end

    // Next-state logic: mode change, tick routing, slot counting and frame alignment
    always_comb begin
        state_n   = state;
        sym_cnt_n = sym_cnt;
        ch_idx_n  = ch_idx;
        cur_ch    = ch_idx;
        cur_cnt   = sym_cnt;
        d1_n      = bus.ds1_out;
        d2_n      = bus.ds2_out;
        d3_n      = bus.ds3_out;
        v1_n      = 1'b0;
        v2_n      = 1'b0;
        v3_n      = 1'b0;
        err_n     = bus.sync_err;
        n_eff     = (bus.switch_clk_cycles == 3'd0) ? 3'd1 : bus.switch_clk_cycles;

        if (bus.mode != mode_q) begin
            // Restart the frame; a coincident tick is dropped
            sym_cnt_n = '0;
            ch_idx_n  = CW'(1);
            state_n   = (bus.mode == 2'b00) ? IDLE : RUN;
        end else begin
            state_n = (mode_q == 2'b00) ? IDLE : RUN;
            if (tick && state == RUN) begin
                // Misaligned frame_sync: treat this tick as symbol 0 of the DS1 slot
                if (bus.frame_sync && !(ch_idx == CW'(1) && sym_cnt == 3'd0)) begin
                    err_n   = 1'b1;
                    cur_ch  = CW'(1);
                    cur_cnt = '0;
                end
                case (cur_ch)
                    CW'(2):  begin d2_n = bus.mux_data; v2_n = 1'b1; end
                    CW'(3):  begin d3_n = bus.mux_data; v3_n = 1'b1; end
                    default: begin d1_n = bus.mux_data; v1_n = 1'b1; end
                endcase
                if (cur_cnt >= n_eff - 3'd1) begin
                    sym_cnt_n = '0;
                    case (mode_q)
                        2'b10:   ch_idx_n = (cur_ch == CW'(1)) ? CW'(2) : CW'(1);
                        2'b11:   ch_idx_n = (cur_ch == CW'(3)) ? CW'(1) : cur_ch + CW'(1);
                        default: ch_idx_n = CW'(1);
                    endcase
                end else begin
                    sym_cnt_n = cur_cnt + 3'd1;
                end
            end
        end

        act_n = (state_n == RUN) ? 2'(ch_idx_n) : 2'd0;
    end
endmodule

// File: tb/tb_data_demux_module.sv
// Directed table-driven bench for data_demux_module.
module tb_data_demux_module;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    data_demux_module_if #(.DW(8)) bus ();

    data_demux_module #(.DW(8), .CH_MAX(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic [2:0] scc;
        logic       fs;
        logic [7:0] data;
        logic [2:0] v;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [7:0] d3;
        logic [1:0] act;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic add(input logic [1:0] mode, input logic [2:0] scc, input logic fs,
                       input logic [7:0] data, input logic [2:0] v, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3, input logic [1:0] act,
                       input logic err);
        vec_t r;
        r.mode = mode; r.scc = scc; r.fs = fs; r.data = data; r.v = v;
        r.d1 = d1; r.d2 = d2; r.d3 = d3; r.act = act; r.err = err;
        vecs.push_back(r);
    endtask

    function automatic logic [2:0] valids();
        return {bus.ds3_valid, bus.ds2_valid, bus.ds1_valid};
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // mode 01, N=5
        for (int i = 0; i < 5; i++) add(2'd1, 3'd5, 1'b0, 8'h0F, 3'b001, 8'h0F, 8'h00, 8'h00, 2'd1, 1'b0);
        // mode 11, N=2 round-robin (first row is the dropped mode-change tick)
        add(2'd3, 3'd2, 1'b0, 8'h00, 3'b000, 8'h0F, 8'h00, 8'h00, 2'd1, 1'b0);
        add(2'd3, 3'd2, 1'b0, 8'h0F, 3'b001, 8'h0F, 8'h00, 8'h00, 2'd1, 1'b0);
        add(2'd3, 3'd2, 1'b0, 8'h0F, 3'b001, 8'h0F, 8'h00, 8'h00, 2'd2, 1'b0);
        add(2'd3, 3'd2, 1'b0, 8'hCC, 3'b010, 8'h0F, 8'hCC, 8'h00, 2'd2, 1'b0);
        add(2'd3, 3'd2, 1'b0, 8'hCC, 3'b010, 8'h0F, 8'hCC, 8'h00, 2'd3, 1'b0);
        add(2'd3, 3'd2, 1'b0, 8'h55, 3'b100, 8'h0F, 8'hCC, 8'h55, 2'd3, 1'b0);
        add(2'd3, 3'd2, 1'b0, 8'h55, 3'b100, 8'h0F, 8'hCC, 8'h55, 2'd1, 1'b0);
        // mode 10, then switch to 11 mid-slot (ch2, cnt1)
        add(2'd2, 3'd2, 1'b0, 8'h99, 3'b000, 8'h0F, 8'hCC, 8'h55, 2'd1, 1'b0);
        add(2'd2, 3'd2, 1'b0, 8'h11, 3'b001, 8'h11, 8'hCC, 8'h55, 2'd1, 1'b0);
        add(2'd2, 3'd2, 1'b0, 8'h22, 3'b001, 8'h22, 8'hCC, 8'h55, 2'd2, 1'b0);
        add(2'd2, 3'd2, 1'b0, 8'h33, 3'b010, 8'h22, 8'h33, 8'h55, 2'd2, 1'b0);
        add(2'd3, 3'd2, 1'b0, 8'h44, 3'b000, 8'h22, 8'h33, 8'h55, 2'd1, 1'b0);
        add(2'd3, 3'd2, 1'b0, 8'h66, 3'b001, 8'h66, 8'h33, 8'h55, 2'd1, 1'b0);
        // mode 10, N=1, misaligned frame_sync on a ch2 tick
        add(2'd2, 3'd1, 1'b0, 8'hE0, 3'b000, 8'h66, 8'h33, 8'h55, 2'd1, 1'b0);
        add(2'd2, 3'd1, 1'b0, 8'h77, 3'b001, 8'h77, 8'h33, 8'h55, 2'd2, 1'b0);
        add(2'd2, 3'd1, 1'b1, 8'hAA, 3'b001, 8'hAA, 8'h33, 8'h55, 2'd2, 1'b1);
        add(2'd2, 3'd1, 1'b0, 8'hBB, 3'b010, 8'hAA, 8'hBB, 8'h55, 2'd1, 1'b1);
        // switch_clk_cycles=0 acts as N=1
        add(2'd2, 3'd0, 1'b0, 8'hC1, 3'b001, 8'hC1, 8'hBB, 8'h55, 2'd2, 1'b1);
        add(2'd2, 3'd0, 1'b0, 8'hC2, 3'b010, 8'hC1, 8'hC2, 8'h55, 2'd1, 1'b1);
        add(2'd2, 3'd0, 1'b0, 8'hC3, 3'b001, 8'hC3, 8'hC2, 8'h55, 2'd2, 1'b1);
        // N shrinks mid-slot: >= compare wraps immediately
        add(2'd2, 3'd4, 1'b0, 8'hE1, 3'b010, 8'hC3, 8'hE1, 8'h55, 2'd2, 1'b1);
        add(2'd2, 3'd4, 1'b0, 8'hE2, 3'b010, 8'hC3, 8'hE2, 8'h55, 2'd2, 1'b1);
        add(2'd2, 3'd2, 1'b0, 8'hE3, 3'b010, 8'hC3, 8'hE3, 8'h55, 2'd1, 1'b1);
        // IDLE: ticks ignored
        add(2'd0, 3'd2, 1'b0, 8'hD0, 3'b000, 8'hC3, 8'hE3, 8'h55, 2'd0, 1'b1);
        add(2'd0, 3'd2, 1'b0, 8'hDD, 3'b000, 8'hC3, 8'hE3, 8'h55, 2'd0, 1'b1);

        // Reset with symbol_clk toggling
        rst_n                 = 1'b0;
        bus.symbol_clk        = 1'b0;
        bus.mode              = 2'd1;
        bus.switch_clk_cycles = 3'd5;
        bus.frame_sync        = 1'b0;
        bus.mux_data          = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.symbol_clk = ~bus.symbol_clk;
        end
        @(negedge clk);
        bus.symbol_clk = 1'b1;
        chk("rst_valid", 32'(valids()), 32'd0);
        chk("rst_outs", {bus.ds1_out, bus.ds2_out, bus.ds3_out}, 32'd0);
        chk("rst_act", 32'(bus.active_ch), 32'd0);
        chk("rst_err", 32'(bus.sync_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_valid0", 32'(valids()), 32'd0);
        @(negedge clk);
        bus.symbol_clk = 1'b0;
        chk("rel_valid1", 32'(valids()), 32'd0);
        @(negedge clk);
        chk("rel_valid2", 32'(valids()), 32'd0);
        chk("rel_act", 32'(bus.active_ch), 32'd1);
        chk("rel_outs", {bus.ds1_out, bus.ds2_out, bus.ds3_out}, 32'd0);

        // One tick per row: drive, sample one clk later, then confirm the pulse ended
        foreach (vecs[k]) begin
            @(negedge clk);
            bus.mode              = vecs[k].mode;
            bus.switch_clk_cycles = vecs[k].scc;
            bus.frame_sync        = vecs[k].fs;
            bus.mux_data          = vecs[k].data;
            bus.symbol_clk        = 1'b1;
            @(negedge clk);
            bus.symbol_clk = 1'b0;
            bus.frame_sync = 1'b0;
            chk($sformatf("v%0d_valid", k), 32'(valids()), 32'(vecs[k].v));
            chk($sformatf("v%0d_ds1", k), 32'(bus.ds1_out), 32'(vecs[k].d1));
            chk($sformatf("v%0d_ds2", k), 32'(bus.ds2_out), 32'(vecs[k].d2));
            chk($sformatf("v%0d_ds3", k), 32'(bus.ds3_out), 32'(vecs[k].d3));
            chk($sformatf("v%0d_act", k), 32'(bus.active_ch), 32'(vecs[k].act));
            chk($sformatf("v%0d_err", k), 32'(bus.sync_err), 32'(vecs[k].err));
            @(negedge clk);
            chk($sformatf("v%0d_pulse_end", k), 32'(valids()), 32'd0);
        end

        // Reset clears the sticky error and the data registers
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst2_err", 32'(bus.sync_err), 32'd0);
        chk("rst2_outs", {bus.ds1_out, bus.ds2_out, bus.ds3_out}, 32'd0);
        chk("rst2_act", 32'(bus.active_ch), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
